stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshake and a registered output stage. It is the successor to the fixed 16-bit two-input word mux. It merges several word streams (ALU results, memory read data, I/O) onto one datapath bus. Arbitration is round-robin, fixed-priority or externally selected, and data is held until the consumer accepts it.

## Interface
- WIDTH, 16: data word width in bits
- N, 4: number of input channels, 2..16
- MODE, 0: arbitration mode; 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = external select
- SW (derived, $clog2(N)): select width, not overridable

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  N  per-channel data valid
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; combinational
- sel  in  SW  channel select, used only in MODE 2
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered word
- out_sel  out  SW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data

## Operation
- **Load enable.** load = !out_valid || out_ready. The output register can take a new word in the same cycle its current word is drained.
- **Grant.** One-hot grant[N-1:0], computed combinationally from in_valid and the mode. At most one bit is set, and it is set only when the chosen channel's in_valid is high.
  - MODE 0: first valid channel searching upward from ptr, wrapping N-1 to 0.
  - MODE 1: lowest-index valid channel.
  - MODE 2: grant[sel] = in_valid[sel]. Other channels are never granted. If sel >= N, no grant.
- **Ready.** in_ready[i] = grant[i] && load.
- **Transfer.** A transfer occurs on channel g when in_valid[g] && in_ready[g]. At that edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
- **Drain.** When out_ready && out_valid and no transfer occurs, out_valid <= 0. out_data and out_sel hold their last value.
- **Round-robin pointer (ptr, SW bits, MODE 0 only).** On a transfer from g, ptr <= (g == N-1) ? 0 : g+1. With no transfer, ptr holds. In MODE 1 and 2, ptr stays 0.
- **Upstream rules.** An upstream source must hold in_valid and in_data stable until accepted. The block never drops or duplicates a word.
- **Reset.** rst_n low clears, asynchronously:
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0
  - in_ready = 0 for the duration, because load is forced low while rst_n is low.
  - Words pending on inputs are not lost; they are accepted after release.
  - A word held in the output register is discarded.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid high.
- Throughput: one word per cycle with out_ready held high, including back-to-back transfers from the same channel.
- Fairness, MODE 0: with all N channels valid continuously and out_ready high, grants rotate 0,1,…,N-1,0. Each channel gets exactly one of every N transfers.
- Backpressure: with out_ready low and out_valid high, all in_ready are 0. out_data, out_sel and ptr hold.
- Combinational paths:
  - out_ready → in_ready
  - in_valid → in_ready
  - sel → in_ready
  - No path from in_valid to out_valid within a cycle.
- Simultaneous drain and load in the same edge: the new word replaces the old one, and out_valid stays 1.

## Structure
- Package stream_mux_pkg:
  - mode constants MUX_RR = 0, MUX_PRIO = 1, MUX_EXT = 2
  - function onehot_to_idx(N-bit) → SW bits
- Sub-module rr_arbiter:
  - parameters N, MODE
  - inputs req[N], ptr, sel
  - output grant[N]
  - purely combinational; holds all mode-dependent grant logic
- stream_mux holds the output register, ptr, load/ready logic and the data select. The data select is an AND-OR of grant against in_data.

## Test plan
- **Reset.** Hold rst_n low with all in_valid = 1 → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0. After release, first grant (MODE 0) = channel 0.
- **Round-robin rotation.** N = 4, MODE 0, all valid, data 0xA000+i, out_ready = 1 → out_sel sequence 0,1,2,3,0. out_data = 0xA000,0xA001,… one per cycle after a 1-cycle latency.
- **Backpressure.** N = 4, MODE 0. out_ready = 0 for 3 cycles with word 0x1234 from ch2 held → out_data stays 0x1234, out_sel = 2, in_ready = 0. Raise out_ready → next grant is ch3 (ptr = 3), not ch0.
- **Fixed priority.** MODE 1, ch1 and ch3 valid continuously → only ch1 accepted. Drop ch1 → ch3 accepted the next cycle.
- **External select.** MODE 2, N = 2, WIDTH = 16, sel = 1, X = 0x00FF on ch0, Y = 0xFF00 on ch1, both valid → out_data = 0xFF00, out_sel = 1. Set sel = 0 → next word 0x00FF.
- **Reset mid-operation.** Assert rst_n low while out_valid = 1 and ptr = 2 → out_valid drops immediately, without waiting for a clock edge. After release, ptr = 0 and ch0 is granted first.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared arbitration-mode constants and the grant-to-index helper for stream_mux.
package stream_mux_pkg;

    localparam int MUX_RR   = 0;
    localparam int MUX_PRIO = 1;
    localparam int MUX_EXT  = 2;

    // Sized for the largest legal N (16); callers truncate the result to their SW.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational one-hot grant for stream_mux: round-robin, fixed priority or external select.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MUX_RR,
    localparam int SW  = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rr_grant;
    logic [N-1:0] pr_grant;
    logic [N-1:0] ex_grant;
    logic         rr_found;
    logic         pr_found;
    int           idx;

    always_comb begin
        rr_grant = '0;
        pr_grant = '0;
        ex_grant = '0;
        rr_found = 1'b0;
        pr_found = 1'b0;
        idx      = 0;
        // Search upward from ptr, wrapping N-1 back to 0.
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!rr_found && req[idx]) begin
                rr_grant[idx] = 1'b1;
                rr_found      = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!pr_found && req[k]) begin
                pr_grant[k] = 1'b1;
                pr_found    = 1'b1;
            end
        end
        if (int'(sel) < N) ex_grant[sel] = req[sel];
    end

    assign grant = (MODE == MUX_RR)   ? rr_grant :
                   (MODE == MUX_PRIO) ? pr_grant : ex_grant;

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output word.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = MUX_RR,
    localparam int SW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel,
    input  logic                 out_ready
);

    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] mux_data;
    logic             load;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]    out_sel_q,   out_sel_d;
    logic [SW-1:0]    ptr_q,       ptr_d;

    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .sel   (sel),
        .grant (grant)
    );

    // Gating with rst_n keeps pending input words un-accepted while reset is held.
    assign load      = rst_n && (!out_valid_q || out_ready);
    assign in_ready  = grant & {N{load}};
    assign xfer      = |in_ready;
    assign grant_idx = SW'(onehot_to_idx(16'(grant)));

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_sel_d   = grant_idx;
            if (MODE == MUX_RR) begin
                ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: round-robin, fixed-priority and external-select instances.
module tb_stream_mux;

    logic clk;
    logic rst_n;

    // Round-robin instance, N=4
    logic [3:0]  rr_valid;
    logic [63:0] rr_data;
    logic [3:0]  rr_ready;
    logic [1:0]  rr_sel;
    logic        rr_ovalid;
    logic [15:0] rr_odata;
    logic [1:0]  rr_osel;
    logic        rr_oready;

    // Fixed-priority instance, N=4
    logic [3:0]  pr_valid;
    logic [63:0] pr_data;
    logic [3:0]  pr_ready;
    logic [1:0]  pr_sel;
    logic        pr_ovalid;
    logic [15:0] pr_odata;
    logic [1:0]  pr_osel;
    logic        pr_oready;

    // External-select instance, N=2
    logic [1:0]  ex_valid;
    logic [31:0] ex_data;
    logic [1:0]  ex_ready;
    logic [0:0]  ex_sel;
    logic        ex_ovalid;
    logic [15:0] ex_odata;
    logic [0:0]  ex_osel;
    logic        ex_oready;

    int n_cmp;
    int n_err;

    stream_mux #(.WIDTH(16), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data),
        .in_ready(rr_ready), .sel(rr_sel), .out_valid(rr_ovalid),
        .out_data(rr_odata), .out_sel(rr_osel), .out_ready(rr_oready)
    );

    stream_mux #(.WIDTH(16), .N(4), .MODE(1)) u_pr (
        .clk(clk), .rst_n(rst_n), .in_valid(pr_valid), .in_data(pr_data),
        .in_ready(pr_ready), .sel(pr_sel), .out_valid(pr_ovalid),
        .out_data(pr_odata), .out_sel(pr_osel), .out_ready(pr_oready)
    );

    stream_mux #(.WIDTH(16), .N(2), .MODE(2)) u_ex (
        .clk(clk), .rst_n(rst_n), .in_valid(ex_valid), .in_data(ex_data),
        .in_ready(ex_ready), .sel(ex_sel), .out_valid(ex_ovalid),
        .out_data(ex_odata), .out_sel(ex_osel), .out_ready(ex_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        rr_valid  = 4'hF;
        rr_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        rr_sel    = '0;
        rr_oready = 1'b1;
        pr_valid  = '0;
        pr_data   = '0;
        pr_sel    = '0;
        pr_oready = 1'b1;
        ex_valid  = '0;
        ex_data   = '0;
        ex_sel    = '0;
        ex_oready = 1'b1;

        // Reset held with all inputs valid
        step();
        step();
        chk("rst_in_ready", 32'(rr_ready), 32'h0);
        chk("rst_out_valid", 32'(rr_ovalid), 32'h0);
        chk("rst_out_data", 32'(rr_odata), 32'h0);
        chk("rst_out_sel", 32'(rr_osel), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_first_grant", 32'(rr_ready), 32'h1);

        // Round-robin rotation 0,1,2,3,0 one word per cycle
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_valid", 32'(rr_ovalid), 32'h1);
            chk("rr_sel", 32'(rr_osel), 32'(k % 4));
            chk("rr_data", 32'(rr_odata), 32'hA000 + 32'(k % 4));
        end

        // Backpressure: only ch2 valid with 0x1234 (ptr is 1 now)
        rr_valid = 4'b0100;
        rr_data  = {16'hC003, 16'h1234, 16'hC001, 16'hC000};
        #1;
        chk("bp_grant_ch2", 32'(rr_ready), 32'h4);
        step();
        chk("bp_load_data", 32'(rr_odata), 32'h1234);
        rr_oready = 1'b0;
        rr_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(rr_ready), 32'h0);
            step();
            chk("bp_hold_data", 32'(rr_odata), 32'h1234);
            chk("bp_hold_sel", 32'(rr_osel), 32'h2);
            chk("bp_hold_valid", 32'(rr_ovalid), 32'h1);
        end
        rr_oready = 1'b1;
        #1;
        chk("bp_next_grant_ch3", 32'(rr_ready), 32'h8);
        step();
        chk("bp_after_sel", 32'(rr_osel), 32'h3);
        chk("bp_after_data", 32'(rr_odata), 32'hC003);

        // Move ptr to 2 with two more transfers (ch0, ch1)
        step();
        chk("mid_sel0", 32'(rr_osel), 32'h0);
        step();
        chk("mid_sel1", 32'(rr_osel), 32'h1);
        chk("mid_valid", 32'(rr_ovalid), 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(rr_ovalid), 32'h0);
        chk("async_out_data", 32'(rr_odata), 32'h0);
        chk("async_in_ready", 32'(rr_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(rr_ready), 32'h1);
        step();
        chk("post_rst_sel", 32'(rr_osel), 32'h0);
        chk("post_rst_data", 32'(rr_odata), 32'hC000);
        rr_valid = '0;
        step();
        chk("rr_drain_valid", 32'(rr_ovalid), 32'h0);
        chk("rr_drain_data_hold", 32'(rr_odata), 32'hC000);

        // Fixed priority: ch1 and ch3 valid
        pr_valid = 4'b1010;
        pr_data  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        #1;
        chk("pr_grant_ch1", 32'(pr_ready), 32'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pr_sel_ch1", 32'(pr_osel), 32'h1);
            chk("pr_data_ch1", 32'(pr_odata), 32'hB001);
            chk("pr_ready_ch1", 32'(pr_ready), 32'h2);
        end
        pr_valid = 4'b1000;
        #1;
        chk("pr_grant_ch3", 32'(pr_ready), 32'h8);
        step();
        chk("pr_sel_ch3", 32'(pr_osel), 32'h3);
        chk("pr_data_ch3", 32'(pr_odata), 32'hB003);
        pr_valid = '0;
        step();
        chk("pr_drain_valid", 32'(pr_ovalid), 32'h0);
        chk("pr_drain_data_hold", 32'(pr_odata), 32'hB003);

        // External select, N=2
        ex_valid = 2'b11;
        ex_data  = {16'hFF00, 16'h00FF};
        ex_sel   = 1'b1;
        #1;
        chk("ex_grant_ch1", 32'(ex_ready), 32'h2);
        step();
        chk("ex_data_y", 32'(ex_odata), 32'hFF00);
        chk("ex_sel_1", 32'(ex_osel), 32'h1);
        ex_sel = 1'b0;
        #1;
        chk("ex_grant_ch0", 32'(ex_ready), 32'h1);
        step();
        chk("ex_data_x", 32'(ex_odata), 32'h00FF);
        chk("ex_sel_0", 32'(ex_osel), 32'h0);
        chk("ex_valid_kept", 32'(ex_ovalid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
